// File: rtl/ahb_fetch_data_arbiter.sv
// ---------------------------------------------------------------------------
// ahb_fetch_data_arbiter
//
// Shares one AHB3-Lite slave port between the instruction-fetch master (ins)
// and the load/store master (dat). Each master owns a one-entry holding
// register for its address phase; a master whose request loses arbitration
// is captured into that register and stalled with its hready low until the
// held transfer is issued to the slave.
//
// Every forwarded transfer is issued as NONSEQ, so interleaving the two
// masters never breaks a burst on the slave side.
//
// Parameters
//   HADDR_SIZE  address width
//   HDATA_SIZE  data width
//   ARB_MODE    0 = round-robin, 1 = fixed priority (dat wins)
//
// Ports
//   clk, rst                       clock, asynchronous active-high reset
//   ins_* / dat_* (inputs)         master address phase and write data
//   ins_hready / dat_hready        per-master ready (low while pending)
//   ins_hrdata / dat_hrdata        read data, broadcast from s_hrdata
//   ins_hresp / dat_hresp          error response, data-phase owner only
//   s_* (outputs)                  slave address phase and write data
//   s_hready, s_hrdata, s_hresp    slave responses
// ---------------------------------------------------------------------------
module ahb_fetch_data_arbiter #(
    parameter int HADDR_SIZE = 32,
    parameter int HDATA_SIZE = 32,
    parameter int ARB_MODE   = 0
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic [1:0]            ins_htrans,
    input  logic [HADDR_SIZE-1:0] ins_haddr,
    input  logic                  ins_hwrite,
    input  logic [2:0]            ins_hsize,
    input  logic [HDATA_SIZE-1:0] ins_hwdata,
    output logic                  ins_hready,
    output logic [HDATA_SIZE-1:0] ins_hrdata,
    output logic                  ins_hresp,

    input  logic [1:0]            dat_htrans,
    input  logic [HADDR_SIZE-1:0] dat_haddr,
    input  logic                  dat_hwrite,
    input  logic [2:0]            dat_hsize,
    input  logic [HDATA_SIZE-1:0] dat_hwdata,
    output logic                  dat_hready,
    output logic [HDATA_SIZE-1:0] dat_hrdata,
    output logic                  dat_hresp,

    output logic [1:0]            s_htrans,
    output logic [HADDR_SIZE-1:0] s_haddr,
    output logic                  s_hwrite,
    output logic [2:0]            s_hsize,
    output logic [HDATA_SIZE-1:0] s_hwdata,
    input  logic                  s_hready,
    input  logic [HDATA_SIZE-1:0] s_hrdata,
    input  logic                  s_hresp
);

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    // Owner encoding shared by the data-phase owner and the round-robin
    // pointer (the pointer only ever holds INS or DAT).
    typedef enum logic [1:0] {
        OWN_NONE = 2'b00,
        OWN_INS  = 2'b01,
        OWN_DAT  = 2'b10
    } owner_e;

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    logic                  pend_ins;
    logic [HADDR_SIZE-1:0] hold_ins_addr;
    logic                  hold_ins_write;
    logic [2:0]            hold_ins_size;

    logic                  pend_dat;
    logic [HADDR_SIZE-1:0] hold_dat_addr;
    logic                  hold_dat_write;
    logic [2:0]            hold_dat_size;

    owner_e                dph_own;
    owner_e                dph_own_nxt;
    owner_e                rr_last;

    // Last address-phase values driven to the slave; shown while no grant.
    logic [HADDR_SIZE-1:0] last_addr;
    logic                  last_write;
    logic [2:0]            last_size;

    // -----------------------------------------------------------------------
    // Request qualification (BUSY counts as IDLE)
    // -----------------------------------------------------------------------
    logic ins_active, dat_active;
    logic ins_live, dat_live;
    logic ins_cand, dat_cand;

    assign ins_active = (ins_htrans == HTRANS_NONSEQ) || (ins_htrans == HTRANS_SEQ);
    assign dat_active = (dat_htrans == HTRANS_NONSEQ) || (dat_htrans == HTRANS_SEQ);

    // A pending master keeps hready low, so its live inputs are stale.
    assign ins_live = ins_active & ~pend_ins;
    assign dat_live = dat_active & ~pend_dat;

    assign ins_cand = pend_ins | ins_live;
    assign dat_cand = pend_dat | dat_live;

    // -----------------------------------------------------------------------
    // Grant
    // -----------------------------------------------------------------------
    logic grant_ins, grant_dat, grant_any;

    always_comb begin
        grant_ins = 1'b0;
        grant_dat = 1'b0;
        if (ins_cand && dat_cand) begin
            if (ARB_MODE == 1) begin
                grant_dat = 1'b1;
            end else if (rr_last == OWN_INS) begin
                grant_dat = 1'b1;
            end else begin
                grant_ins = 1'b1;
            end
        end else if (ins_cand) begin
            grant_ins = 1'b1;
        end else if (dat_cand) begin
            grant_dat = 1'b1;
        end
    end

    assign grant_any = grant_ins | grant_dat;

    // -----------------------------------------------------------------------
    // Address-phase source select
    // -----------------------------------------------------------------------
    logic [HADDR_SIZE-1:0] src_addr;
    logic                  src_write;
    logic [2:0]            src_size;

    always_comb begin
        src_addr  = last_addr;
        src_write = last_write;
        src_size  = last_size;
        if (grant_ins) begin
            if (pend_ins) begin
                src_addr  = hold_ins_addr;
                src_write = hold_ins_write;
                src_size  = hold_ins_size;
            end else begin
                src_addr  = ins_haddr;
                src_write = ins_hwrite;
                src_size  = ins_hsize;
            end
        end else if (grant_dat) begin
            if (pend_dat) begin
                src_addr  = hold_dat_addr;
                src_write = hold_dat_write;
                src_size  = hold_dat_size;
            end else begin
                src_addr  = dat_haddr;
                src_write = dat_hwrite;
                src_size  = dat_hsize;
            end
        end
    end

    // rst gates s_htrans so a master still driving NONSEQ during reset
    // cannot leak a transfer onto the slave.
    assign s_htrans = (grant_any && !rst) ? HTRANS_NONSEQ : HTRANS_IDLE;
    assign s_haddr  = src_addr;
    assign s_hwrite = src_write;
    assign s_hsize  = src_size;

    // -----------------------------------------------------------------------
    // Data-phase owner: next-state logic and register
    // -----------------------------------------------------------------------
    always_comb begin
        dph_own_nxt = OWN_NONE;
        if (grant_ins) begin
            dph_own_nxt = OWN_INS;
        end else if (grant_dat) begin
            dph_own_nxt = OWN_DAT;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dph_own <= OWN_NONE;
            rr_last <= OWN_INS;
        end else if (s_hready) begin
            dph_own <= dph_own_nxt;
            if (grant_any) begin
                rr_last <= dph_own_nxt;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Holding registers and last-driven address phase
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_ins       <= 1'b0;
            hold_ins_addr  <= '0;
            hold_ins_write <= 1'b0;
            hold_ins_size  <= 3'b000;
        end else if (s_hready) begin
            if (grant_ins && pend_ins) begin
                pend_ins <= 1'b0;
            end else if (ins_live && !grant_ins) begin
                pend_ins       <= 1'b1;
                hold_ins_addr  <= ins_haddr;
                hold_ins_write <= ins_hwrite;
                hold_ins_size  <= ins_hsize;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_dat       <= 1'b0;
            hold_dat_addr  <= '0;
            hold_dat_write <= 1'b0;
            hold_dat_size  <= 3'b000;
        end else if (s_hready) begin
            if (grant_dat && pend_dat) begin
                pend_dat <= 1'b0;
            end else if (dat_live && !grant_dat) begin
                pend_dat       <= 1'b1;
                hold_dat_addr  <= dat_haddr;
                hold_dat_write <= dat_hwrite;
                hold_dat_size  <= dat_hsize;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_addr  <= '0;
            last_write <= 1'b0;
            last_size  <= 3'b000;
        end else if (s_hready && grant_any) begin
            last_addr  <= src_addr;
            last_write <= src_write;
            last_size  <= src_size;
        end
    end

    // -----------------------------------------------------------------------
    // Master-side responses
    // -----------------------------------------------------------------------
    assign ins_hready = rst | (s_hready & ~pend_ins);
    assign dat_hready = rst | (s_hready & ~pend_dat);

    assign ins_hrdata = s_hrdata;
    assign dat_hrdata = s_hrdata;

    assign ins_hresp = s_hresp & (dph_own == OWN_INS);
    assign dat_hresp = s_hresp & (dph_own == OWN_DAT);

    always_comb begin
        s_hwdata = '0;
        case (dph_own)
            OWN_INS: s_hwdata = ins_hwdata;
            OWN_DAT: s_hwdata = dat_hwdata;
            default: s_hwdata = '0;
        endcase
    end

endmodule

// File: tb/tb_ahb_fetch_data_arbiter.sv
module tb_ahb_fetch_data_arbiter;

    localparam logic [31:0] INS_WD = 32'h1111_1111;
    localparam logic [31:0] DAT_WD = 32'hDEAD_BEEF;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  ins_htrans = 2'b00, dat_htrans = 2'b00;
    logic [31:0] ins_haddr = '0, dat_haddr = '0;
    logic        ins_hwrite = 1'b0, dat_hwrite = 1'b0;
    logic [2:0]  ins_hsize = 3'd2, dat_hsize = 3'd0;
    logic [31:0] ins_hwdata = INS_WD, dat_hwdata = DAT_WD;
    logic        s_hready = 1'b1, s_hresp = 1'b0;
    logic [31:0] s_hrdata = '0;

    // round-robin instance outputs
    logic        ins_hready, dat_hready, ins_hresp, dat_hresp, s_hwrite;
    logic [31:0] ins_hrdata, dat_hrdata, s_haddr, s_hwdata;
    logic [1:0]  s_htrans;
    logic [2:0]  s_hsize;
    // fixed-priority instance outputs
    logic        fx_ins_hready, fx_dat_hready, fx_ins_hresp, fx_dat_hresp, fx_s_hwrite;
    logic [31:0] fx_ins_hrdata, fx_dat_hrdata, fx_s_haddr, fx_s_hwdata;
    logic [1:0]  fx_s_htrans;
    logic [2:0]  fx_s_hsize;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    ahb_fetch_data_arbiter #(.HADDR_SIZE(32), .HDATA_SIZE(32), .ARB_MODE(0)) u_rr (
        .clk(clk), .rst(rst),
        .ins_htrans(ins_htrans), .ins_haddr(ins_haddr), .ins_hwrite(ins_hwrite),
        .ins_hsize(ins_hsize), .ins_hwdata(ins_hwdata), .ins_hready(ins_hready),
        .ins_hrdata(ins_hrdata), .ins_hresp(ins_hresp),
        .dat_htrans(dat_htrans), .dat_haddr(dat_haddr), .dat_hwrite(dat_hwrite),
        .dat_hsize(dat_hsize), .dat_hwdata(dat_hwdata), .dat_hready(dat_hready),
        .dat_hrdata(dat_hrdata), .dat_hresp(dat_hresp),
        .s_htrans(s_htrans), .s_haddr(s_haddr), .s_hwrite(s_hwrite), .s_hsize(s_hsize),
        .s_hwdata(s_hwdata), .s_hready(s_hready), .s_hrdata(s_hrdata), .s_hresp(s_hresp)
    );

    ahb_fetch_data_arbiter #(.HADDR_SIZE(32), .HDATA_SIZE(32), .ARB_MODE(1)) u_fx (
        .clk(clk), .rst(rst),
        .ins_htrans(ins_htrans), .ins_haddr(ins_haddr), .ins_hwrite(ins_hwrite),
        .ins_hsize(ins_hsize), .ins_hwdata(ins_hwdata), .ins_hready(fx_ins_hready),
        .ins_hrdata(fx_ins_hrdata), .ins_hresp(fx_ins_hresp),
        .dat_htrans(dat_htrans), .dat_haddr(dat_haddr), .dat_hwrite(dat_hwrite),
        .dat_hsize(dat_hsize), .dat_hwdata(dat_hwdata), .dat_hready(fx_dat_hready),
        .dat_hrdata(fx_dat_hrdata), .dat_hresp(fx_dat_hresp),
        .s_htrans(fx_s_htrans), .s_haddr(fx_s_haddr), .s_hwrite(fx_s_hwrite), .s_hsize(fx_s_hsize),
        .s_hwdata(fx_s_hwdata), .s_hready(s_hready), .s_hrdata(s_hrdata), .s_hresp(s_hresp)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [1:0]  it;  logic [31:0] ia;  logic iw;
        logic [1:0]  dt;  logic [31:0] da;  logic dw;
        logic        sr;  logic        se;
        logic [1:0]  et;  logic [31:0] ea;  logic ew;
        logic        eir; logic        edr; logic [31:0] ewd;
        logic        eie; logic        ede;
    } vec_t;

    vec_t vecs[24];

    function automatic vec_t mk(
        input logic [1:0] it, input logic [31:0] ia, input logic iw,
        input logic [1:0] dt, input logic [31:0] da, input logic dw,
        input logic sr, input logic se,
        input logic [1:0] et, input logic [31:0] ea, input logic ew,
        input logic eir, input logic edr, input logic [31:0] ewd,
        input logic eie, input logic ede);
        vec_t v;
        v.it = it; v.ia = ia; v.iw = iw; v.dt = dt; v.da = da; v.dw = dw;
        v.sr = sr; v.se = se; v.et = et; v.ea = ea; v.ew = ew;
        v.eir = eir; v.edr = edr; v.ewd = ewd; v.eie = eie; v.ede = ede;
        return v;
    endfunction

    initial begin
        //                it  ia          iw  dt  da          dw  sr se  et  ea          ew  ir dr  wd      ie de
        vecs[0]  = mk(2'd0, 32'h0,     0, 2'd0, 32'h0,     0, 1, 0, 2'd0, 32'h0,     0, 1, 1, 32'h0,  0, 0);
        vecs[1]  = mk(2'd2, 32'h100,   0, 2'd0, 32'h0,     0, 1, 0, 2'd2, 32'h100,   0, 1, 1, 32'h0,  0, 0);
        vecs[2]  = mk(2'd0, 32'h0,     0, 2'd0, 32'h0,     0, 1, 0, 2'd0, 32'h100,   0, 1, 1, INS_WD, 0, 0);
        vecs[3]  = mk(2'd2, 32'h100,   0, 2'd2, 32'h2000,  1, 1, 0, 2'd2, 32'h2000,  1, 1, 1, 32'h0,  0, 0);
        vecs[4]  = mk(2'd2, 32'h100,   0, 2'd0, 32'h0,     0, 1, 0, 2'd2, 32'h100,   0, 0, 1, DAT_WD, 0, 0);
        vecs[5]  = mk(2'd0, 32'h0,     0, 2'd0, 32'h0,     0, 1, 0, 2'd0, 32'h100,   0, 1, 1, INS_WD, 0, 0);
        vecs[6]  = mk(2'd2, 32'h104,   0, 2'd2, 32'h2004,  1, 1, 0, 2'd2, 32'h2004,  1, 1, 1, 32'h0,  0, 0);
        vecs[7]  = mk(2'd2, 32'h108,   0, 2'd2, 32'h2008,  1, 1, 0, 2'd2, 32'h104,   0, 0, 1, DAT_WD, 0, 0);
        vecs[8]  = mk(2'd2, 32'h108,   0, 2'd2, 32'h200C,  1, 1, 0, 2'd2, 32'h2008,  1, 1, 0, INS_WD, 0, 0);
        vecs[9]  = mk(2'd2, 32'h10C,   0, 2'd2, 32'h200C,  1, 1, 0, 2'd2, 32'h108,   0, 0, 1, DAT_WD, 0, 0);
        vecs[10] = mk(2'd2, 32'h10C,   0, 2'd2, 32'h2010,  1, 1, 0, 2'd2, 32'h200C,  1, 1, 0, INS_WD, 0, 0);
        vecs[11] = mk(2'd2, 32'h110,   0, 2'd2, 32'h2010,  1, 1, 0, 2'd2, 32'h10C,   0, 0, 1, DAT_WD, 0, 0);
        vecs[12] = mk(2'd0, 32'h0,     0, 2'd2, 32'h2014,  1, 1, 0, 2'd2, 32'h2010,  1, 1, 0, INS_WD, 0, 0);
        vecs[13] = mk(2'd0, 32'h0,     0, 2'd0, 32'h0,     0, 1, 0, 2'd0, 32'h2010,  1, 1, 1, DAT_WD, 0, 0);
        vecs[14] = mk(2'd2, 32'h200,   0, 2'd0, 32'h0,     0, 1, 0, 2'd2, 32'h200,   0, 1, 1, 32'h0,  0, 0);
        vecs[15] = mk(2'd2, 32'h300,   0, 2'd2, 32'h4000,  1, 1, 0, 2'd2, 32'h4000,  1, 1, 1, INS_WD, 0, 0);
        vecs[16] = mk(2'd2, 32'h304,   0, 2'd0, 32'h0,     0, 0, 0, 2'd2, 32'h300,   0, 0, 0, DAT_WD, 0, 0);
        vecs[17] = mk(2'd2, 32'h304,   0, 2'd0, 32'h0,     0, 0, 0, 2'd2, 32'h300,   0, 0, 0, DAT_WD, 0, 0);
        vecs[18] = mk(2'd2, 32'h304,   0, 2'd0, 32'h0,     0, 0, 0, 2'd2, 32'h300,   0, 0, 0, DAT_WD, 0, 0);
        vecs[19] = mk(2'd2, 32'h304,   0, 2'd0, 32'h0,     0, 1, 0, 2'd2, 32'h300,   0, 0, 1, DAT_WD, 0, 0);
        vecs[20] = mk(2'd2, 32'h304,   0, 2'd2, 32'h5000,  0, 1, 0, 2'd2, 32'h5000,  0, 1, 1, INS_WD, 0, 0);
        vecs[21] = mk(2'd2, 32'h304,   0, 2'd0, 32'h0,     0, 0, 1, 2'd2, 32'h304,   0, 0, 0, DAT_WD, 0, 1);
        vecs[22] = mk(2'd2, 32'h304,   0, 2'd0, 32'h0,     0, 1, 1, 2'd2, 32'h304,   0, 0, 1, DAT_WD, 0, 1);
        vecs[23] = mk(2'd2, 32'h600,   0, 2'd2, 32'h7000,  1, 1, 0, 2'd2, 32'h7000,  1, 1, 1, INS_WD, 0, 0);

        // Reset state, with an active master and a stalled slave.
        ins_htrans = 2'd2; ins_haddr = 32'h100; s_hready = 1'b0; s_hresp = 1'b1;
        #3;
        chk("rst s_htrans", {30'd0, s_htrans}, 32'd0);
        chk("rst ins_hready", {31'd0, ins_hready}, 32'd1);
        chk("rst dat_hready", {31'd0, dat_hready}, 32'd1);
        chk("rst hresp", {30'd0, ins_hresp, dat_hresp}, 32'd0);
        chk("rst s_hwdata", s_hwdata, 32'd0);
        ins_htrans = 2'd0; ins_haddr = '0; s_hready = 1'b1; s_hresp = 1'b0;
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 24; i++) begin
            @(posedge clk);
            #1;
            ins_htrans = vecs[i].it; ins_haddr = vecs[i].ia; ins_hwrite = vecs[i].iw;
            dat_htrans = vecs[i].dt; dat_haddr = vecs[i].da; dat_hwrite = vecs[i].dw;
            s_hready = vecs[i].sr; s_hresp = vecs[i].se;
            s_hrdata = 32'hCAFE_0000 | i;
            #3;
            chk($sformatf("v%0d s_htrans", i), {30'd0, s_htrans}, {30'd0, vecs[i].et});
            chk($sformatf("v%0d s_haddr", i), s_haddr, vecs[i].ea);
            chk($sformatf("v%0d s_hwrite", i), {31'd0, s_hwrite}, {31'd0, vecs[i].ew});
            chk($sformatf("v%0d ins_hready", i), {31'd0, ins_hready}, {31'd0, vecs[i].eir});
            chk($sformatf("v%0d dat_hready", i), {31'd0, dat_hready}, {31'd0, vecs[i].edr});
            chk($sformatf("v%0d s_hwdata", i), s_hwdata, vecs[i].ewd);
            chk($sformatf("v%0d ins_hresp", i), {31'd0, ins_hresp}, {31'd0, vecs[i].eie});
            chk($sformatf("v%0d dat_hresp", i), {31'd0, dat_hresp}, {31'd0, vecs[i].ede});
            chk($sformatf("v%0d ins_hrdata", i), ins_hrdata, 32'hCAFE_0000 | i);
            chk($sformatf("v%0d dat_hrdata", i), dat_hrdata, 32'hCAFE_0000 | i);
            if (vecs[i].et == 2'd2)
                chk($sformatf("v%0d s_hsize", i), {29'd0, s_hsize},
                    (vecs[i].ea >= 32'h2000) ? 32'd0 : 32'd2);
        end

        // Reset mid-pending: ins is held (captured at the last edge), dat owns data phase.
        @(posedge clk);
        #1;
        ins_htrans = 2'd2; ins_haddr = 32'h600; dat_htrans = 2'd0; s_hresp = 1'b1;
        #1;
        chk("pre-rst ins_hready", {31'd0, ins_hready}, 32'd0);
        chk("pre-rst s_haddr", s_haddr, 32'h600);
        chk("pre-rst dat_hresp", {31'd0, dat_hresp}, 32'd1);
        rst = 1'b1;
        #1;
        chk("mid-rst s_htrans", {30'd0, s_htrans}, 32'd0);
        chk("mid-rst ins_hready", {31'd0, ins_hready}, 32'd1);
        chk("mid-rst dat_hresp", {31'd0, dat_hresp}, 32'd0);
        rst = 1'b0;
        #1;
        chk("post-rst s_htrans", {30'd0, s_htrans}, 32'd2);
        chk("post-rst s_haddr", s_haddr, 32'h600);
        chk("post-rst ins_hready", {31'd0, ins_hready}, 32'd1);
        chk("post-rst s_hwdata", s_hwdata, 32'd0);

        // Fixed priority: dat wins every edge, ins stays captured.
        @(posedge clk);
        #1;
        rst = 1'b1;
        s_hresp = 1'b0;
        ins_htrans = 2'd2; ins_haddr = 32'h100; ins_hwrite = 1'b0;
        dat_htrans = 2'd2; dat_haddr = 32'h2000; dat_hwrite = 1'b1;
        #1;
        rst = 1'b0;
        #1;
        chk("fx0 s_haddr", fx_s_haddr, 32'h2000);
        chk("fx0 ins_hready", {31'd0, fx_ins_hready}, 32'd1);
        for (int k = 1; k < 5; k++) begin
            @(posedge clk);
            #1;
            dat_haddr = 32'h2000 + 32'(4 * k);
            #2;
            chk($sformatf("fx%0d s_htrans", k), {30'd0, fx_s_htrans}, 32'd2);
            chk($sformatf("fx%0d s_haddr", k), fx_s_haddr, 32'h2000 + 32'(4 * k));
            chk($sformatf("fx%0d s_hwrite", k), {31'd0, fx_s_hwrite}, 32'd1);
            chk($sformatf("fx%0d ins_hready", k), {31'd0, fx_ins_hready}, 32'd0);
            chk($sformatf("fx%0d dat_hready", k), {31'd0, fx_dat_hready}, 32'd1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
